mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between instruction fetch (IF port) and the load/store unit (MEM port, driven by decoded mem_read_en/mem_write_en/l_s_mode).
- Fixed priority: data over fetch. Sequences each bus transaction with a req/ack handshake and returns registered read data.
- Produces the per-stage stall signals that hold the pipeline while a port waits.
- Sits between the IF/MEM stages and the memory or bus wrapper.

Parameters:
- W, 32, word width (= WORD_WIDTH).
- LS_W, 2, load/store mode width (= L_S_MODE_W).
- MAX_WAIT, 15, bus cycles allowed before timeout; range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset: asynchronous, active-low (0 = reset).
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  W  fetch address.
- if_rdata  out  W  fetched word.
- if_ready  out  1  one-cycle completion pulse.
- mem_req  in  1  data request, held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  W  data address.
- mem_wdata  in  W  store data.
- mem_l_s_mode  in  LS_W  byte/half/word mode, passed through.
- mem_rdata  out  W  load data.
- mem_ready  out  1  one-cycle completion pulse.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  bus write.
- bus_addr  out  W  bus address.
- bus_wdata  out  W  bus write data.
- bus_l_s_mode  out  LS_W  bus access mode; fetch always uses the word mode.
- bus_rdata  in  W  bus read data, valid when bus_ack = 1.
- bus_ack  in  1  transaction complete.
- stall_if  out  1  = if_req & ~if_ready (combinational).
- stall_mem  out  1  = mem_req & ~mem_ready (combinational).
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All registered outputs are 0: bus_req, bus_we, bus_addr, bus_wdata, bus_l_s_mode, if_rdata, mem_rdata, if_ready, mem_ready, bus_err. Wait counter = 0. Reset mid-transaction aborts it with no ready pulse.
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE:
  - mem_req = 1: latch mem_we, mem_addr, mem_wdata, mem_l_s_mode onto the bus registers; set bus_req = 1; go to BUSY_MEM.
  - Otherwise, if_req = 1: latch if_addr, bus_we = 0, bus_l_s_mode = word mode; set bus_req = 1; go to BUSY_IF.
  - Both asserted: MEM wins; IF stays stalled.
- BUSY_x:
  - Bus outputs are held stable.
  - Wait counter increments each cycle bus_ack = 0.
  - bus_ack = 1: capture bus_rdata into the owning port's rdata (stores capture nothing, rdata unchanged); set x_ready = 1 for the next cycle; bus_req = 0; counter = 0; go to DONE.
  - Counter reaches MAX_WAIT with no ack: bus_req = 0; owning rdata = 0; bus_err = 1 (sticky until reset); x_ready = 1 next cycle; go to DONE.
  - An ack on the same cycle as the timeout counts as an ack: no error.
- DONE: exactly one cycle. The ready pulse is visible. All requests are ignored this cycle so a requester holding its request into the ready cycle is not served twice. Clear ready; go to IDLE.
- Latency: request seen in cycle 0; bus_req high in cycle 1; earliest ack in cycle 1; ready in cycle 2; next grant evaluated in cycle 3. Minimum 3 cycles per transaction.
- The non-granted port's rdata and ready stay unchanged.
- bus_ack outside BUSY states is ignored.
- Requester contract: a port drops or changes its request on the cycle after its ready pulse. Address and data are held while the request is high.
- Outputs other than stall_if and stall_mem are registered. No combinational path from bus_ack to bus_req.

Test Plan:
- IF only: if_addr = 0x0000_0040, ack 1 cycle after bus_req, bus_rdata = 0x2002_0005 -> bus_addr = 0x40, bus_we = 0; if_ready pulses at cycle 2 with if_rdata = 0x2002_0005; stall_if high in cycles 0-1.
- Simultaneous: if_req and mem_req (load, 0x100) in the same cycle -> MEM served first with mem_ready at cycle 2; IF bus_req at cycle 4, if_ready at cycle 5; no double grant.
- Store: mem_we = 1, addr 0x200, wdata 0xDEAD_BEEF, mode byte, ack delayed 4 cycles -> bus outputs stable throughout; mem_ready one pulse; mem_rdata unchanged.
- Timeout: MAX_WAIT = 15, bus_ack never asserted -> bus_req drops after 15 cycles; mem_ready pulses; mem_rdata = 0; bus_err = 1 and stays 1.
- Held request: if_req kept high through the ready cycle -> exactly one transaction, then a new grant in the IDLE cycle after DONE.
- Reset mid-BUSY_MEM: rst = 0 asynchronously -> bus_req = 0 immediately, no mem_ready; after release, a new request proceeds normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory bus arbiter, load/store over fetch
// Sequences one req/ack bus transaction at a time and returns registered read data.
module mem_arbiter #(
  parameter int W         = 32,
  parameter int LS_W      = 2,
  parameter int MAX_WAIT  = 15,
  parameter int WORD_MODE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [W-1:0]    if_addr,
  output logic [W-1:0]    if_rdata,
  output logic            if_ready,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [W-1:0]    mem_addr,
  input  logic [W-1:0]    mem_wdata,
  input  logic [LS_W-1:0] mem_l_s_mode,
  output logic [W-1:0]    mem_rdata,
  output logic            mem_ready,
  output logic            bus_req,
  output logic            bus_we,
  output logic [W-1:0]    bus_addr,
  output logic [W-1:0]    bus_wdata,
  output logic [LS_W-1:0] bus_l_s_mode,
  input  logic [W-1:0]    bus_rdata,
  input  logic            bus_ack,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  localparam logic [7:0]      LAST_WAIT = 8'(MAX_WAIT - 1);
  localparam logic [LS_W-1:0] WORD_LS   = LS_W'(WORD_MODE);

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic       grant_mem, grant_if, finish, timeout, busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          grant_mem  = 1'b1;
          next_state = BUSY_MEM;
        end else if (if_req) begin
          grant_if   = 1'b1;
          next_state = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        busy = 1'b1;
        // an ack arriving on the final wait cycle still wins over the timeout
        if (bus_ack)                     finish  = 1'b1;
        else if (wait_cnt == LAST_WAIT)  timeout = 1'b1;
        if (finish || timeout) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_l_s_mode <= '0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      if_ready     <= 1'b0;
      mem_ready    <= 1'b0;
      bus_err      <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if (grant_mem) begin
        bus_req      <= 1'b1;
        bus_we       <= mem_we;
        bus_addr     <= mem_addr;
        bus_wdata    <= mem_wdata;
        bus_l_s_mode <= mem_l_s_mode;
        wait_cnt     <= '0;
      end else if (grant_if) begin
        bus_req      <= 1'b1;
        bus_we       <= 1'b0;
        bus_addr     <= if_addr;
        bus_wdata    <= '0;
        bus_l_s_mode <= WORD_LS;
        wait_cnt     <= '0;
      end
      if (busy && !finish && !timeout) wait_cnt <= wait_cnt + 8'd1;
      if (finish) begin
        bus_req  <= 1'b0;
        wait_cnt <= '0;
        if (state == BUSY_IF) begin
          if_rdata <= bus_rdata;
          if_ready <= 1'b1;
        end else begin
          if (!bus_we) mem_rdata <= bus_rdata;
          mem_ready <= 1'b1;
        end
      end
      if (timeout) begin
        bus_req  <= 1'b0;
        wait_cnt <= '0;
        bus_err  <= 1'b1;
        if (state == BUSY_IF) begin
          if_rdata <= '0;
          if_ready <= 1'b1;
        end else begin
          mem_rdata <= '0;
          mem_ready <= 1'b1;
        end
      end
    end
  end

  assign stall_if  = if_req  & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

endmodule
